// File: rtl/bms_pkg.sv
// Shared constants, FSM encodings and the button weight helper for button_magnitude_synth.
//   FRAC_BITS     fraction bits of the X/Y/Q setpoints and of the weights
//   WEIGHT_WIDTH  signed Q6.28 weight width
//   SIGN_NEG      per-button subtract mask, bit2=x, bit1=y, bit0=q
package bms_pkg;

    localparam int unsigned FRAC_BITS    = 28;
    localparam int unsigned WEIGHT_WIDTH = 34;
    localparam int unsigned SET_WIDTH    = 32;
    localparam int unsigned NUM_BUTTONS  = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WEIGHT = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // w0=1+x+y+q  w1=1-x+y-q  w2=1-x-y+q  w3=1+x-y-q
    localparam logic [2:0] SIGN_NEG [NUM_BUTTONS] = '{3'b000, 3'b101, 3'b110, 3'b011};

    localparam logic signed [WEIGHT_WIDTH-1:0] ONE_W = WEIGHT_WIDTH'(64'd1 << FRAC_BITS);

    // 1 +/- x +/- y +/- q in Q6.28; cannot overflow since |x|,|y|,|q| < 8
    function automatic logic signed [WEIGHT_WIDTH-1:0] bmsWeight(
        input logic signed [SET_WIDTH-1:0] x,
        input logic signed [SET_WIDTH-1:0] y,
        input logic signed [SET_WIDTH-1:0] q,
        input logic [2:0]                  neg
    );
        logic signed [WEIGHT_WIDTH-1:0] ex, ey, eq;
        ex = WEIGHT_WIDTH'(x);
        ey = WEIGHT_WIDTH'(y);
        eq = WEIGHT_WIDTH'(q);
        return ONE_W + (neg[2] ? -ex : ex) + (neg[1] ? -ey : ey) + (neg[0] ? -eq : eq);
    endfunction

endpackage

// File: rtl/bms_if.sv
// GPIO setpoint/trigger bus and magnitude outputs of button_magnitude_synth.
//   master: GPIO side (drives data, strobes, trigger; observes csr and magnitudes)
//   slave : synthesiser side
interface bms_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAG_WIDTH  = 24
);
    logic [DATA_WIDTH-1:0] gpioData;
    logic                  csrStrobe;
    logic                  xSetStrobe;
    logic                  ySetStrobe;
    logic                  qSetStrobe;
    logic                  sSetStrobe;
    logic                  trigger;
    logic [DATA_WIDTH-1:0] csr;
    logic [MAG_WIDTH-1:0]  mag0;
    logic [MAG_WIDTH-1:0]  mag1;
    logic [MAG_WIDTH-1:0]  mag2;
    logic [MAG_WIDTH-1:0]  mag3;
    logic                  magToggle;
    logic                  magValid;

    modport master (
        output gpioData, csrStrobe, xSetStrobe, ySetStrobe, qSetStrobe, sSetStrobe, trigger,
        input  csr, mag0, mag1, mag2, mag3, magToggle, magValid
    );

    modport slave (
        input  gpioData, csrStrobe, xSetStrobe, ySetStrobe, qSetStrobe, sSetStrobe, trigger,
        output csr, mag0, mag1, mag2, mag3, magToggle, magValid
    );
endinterface

// File: rtl/bms_pipe_mult.sv
// Pipelined signed weight x unsigned sum multiplier; valid and button index ride along.
//   clk, resetN          clock, async active-low reset
//   inValid/inIdx        operand qualifier and button index
//   inWeight, inSum      signed weight, unsigned sum
//   outValid/outIdx      qualifier and index, LATENCY cycles later
//   outProd              signed full-precision product
module bms_pipe_mult #(
    parameter int unsigned W_WIDTH = 34,
    parameter int unsigned S_WIDTH = 26,
    parameter int unsigned LATENCY = 3
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             inValid,
    input  logic [1:0]                       inIdx,
    input  logic signed [W_WIDTH-1:0]        inWeight,
    input  logic [S_WIDTH-1:0]               inSum,
    output logic                             outValid,
    output logic [1:0]                       outIdx,
    output logic signed [W_WIDTH+S_WIDTH:0]  outProd
);
    localparam int unsigned P_WIDTH = W_WIDTH + S_WIDTH + 1;

    logic signed [P_WIDTH-1:0] prodC;
    logic signed [P_WIDTH-1:0] prodPipe  [LATENCY];
    logic [1:0]                idxPipe   [LATENCY];
    logic                      validPipe [LATENCY];

    // Zero-extend the sum so the product is a plain signed multiply
    assign prodC = P_WIDTH'(inWeight) * P_WIDTH'($signed({1'b0, inSum}));

    // Register chain; stage 0 captures the product, the last stage drives the outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < LATENCY; s++) begin
                prodPipe[s]  <= '0;
                idxPipe[s]   <= '0;
                validPipe[s] <= 1'b0;
            end
        end else begin
            prodPipe[0]  <= prodC;
            idxPipe[0]   <= inIdx;
            validPipe[0] <= inValid;
            for (int s = 1; s < LATENCY; s++) begin
                prodPipe[s]  <= prodPipe[s-1];
                idxPipe[s]   <= idxPipe[s-1];
                validPipe[s] <= validPipe[s-1];
            end
        end
    end

    assign outProd  = prodPipe[LATENCY-1];
    assign outIdx   = idxPipe[LATENCY-1];
    assign outValid = validPipe[LATENCY-1];
endmodule

// File: rtl/button_magnitude_synth.sv
// Synthesises four button magnitudes from X/Y/Q/Sum setpoints (inverse delta-over-sum).
//   clk, resetN  clock, async active-low reset
//   bus          bms_if.slave: GPIO data/strobes/trigger in; csr, mag0..3,
//                magToggle, magValid out. csr = {overrun, busy, clampFlags[3:0], 26'b0}
module button_magnitude_synth
    import bms_pkg::*;
#(
    parameter int unsigned MAG_WIDTH    = 24,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MULT_LATENCY = 3
) (
    input  logic clk,
    input  logic resetN,
    bms_if.slave bus
);
    localparam int unsigned SUM_WIDTH  = MAG_WIDTH + 2;
    localparam int unsigned PROD_WIDTH = WEIGHT_WIDTH + SUM_WIDTH + 1;
    localparam int unsigned SHIFT      = FRAC_BITS + 2;
    localparam int unsigned CNT_WIDTH  = $clog2(MULT_LATENCY + 1);

    logic [2:0]                     state, stateNext;
    logic signed [SET_WIDTH-1:0]    xSet, ySet, qSet, xSnap, ySnap, qSnap;
    logic [SUM_WIDTH-1:0]           sumSet, sumSnap;
    logic signed [WEIGHT_WIDTH-1:0] wRaw    [NUM_BUTTONS];
    logic signed [WEIGHT_WIDTH-1:0] weightQ [NUM_BUTTONS];
    logic [3:0]                     clampQ;
    logic [1:0]                     issueCnt;
    logic [CNT_WIDTH-1:0]           drainCnt;
    logic                           busyQ, overrunQ, toggleQ, validQ;
    logic [MAG_WIDTH-1:0]           holdQ   [NUM_BUTTONS];
    logic [MAG_WIDTH-1:0]           magQ    [NUM_BUTTONS];

    logic                           multValid;
    logic [1:0]                     multIdx;
    logic signed [PROD_WIDTH-1:0]   multProd;
    logic [MAG_WIDTH-1:0]           satMag;
    logic                           unusedProdFrac;

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_IDLE;
        else         state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:   if (bus.trigger) stateNext = S_WEIGHT;
            S_WEIGHT: stateNext = S_ISSUE;
            S_ISSUE:  if (issueCnt == 2'd3) stateNext = S_DRAIN;
            S_DRAIN:  if (drainCnt == CNT_WIDTH'(MULT_LATENCY - 1)) stateNext = S_DONE;
            S_DONE:   stateNext = S_IDLE;
            default:  stateNext = S_IDLE;
        endcase
    end

    // Raw weights from the snapshot
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            wRaw[i] = bmsWeight(xSnap, ySnap, qSnap, SIGN_NEG[i]);
        end
    end

    // Shift out Sum/4 and the fraction; negative cannot occur after clamping but maps to 0
    always_comb begin
        satMag = multProd[SHIFT+MAG_WIDTH-1:SHIFT];
        if (multProd[PROD_WIDTH-1])
            satMag = '0;
        else if (|multProd[PROD_WIDTH-2:SHIFT+MAG_WIDTH])
            satMag = '1;
    end
    assign unusedProdFrac = ^multProd[SHIFT-1:0];

    bms_pipe_mult #(
        .W_WIDTH (WEIGHT_WIDTH),
        .S_WIDTH (SUM_WIDTH),
        .LATENCY (MULT_LATENCY)
    ) uMult (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (state == S_ISSUE),
        .inIdx    (issueCnt),
        .inWeight (weightQ[issueCnt]),
        .inSum    (sumSnap),
        .outValid (multValid),
        .outIdx   (multIdx),
        .outProd  (multProd)
    );

    // Setpoints, snapshot, weights, counters, status and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xSet     <= '0;
            ySet     <= '0;
            qSet     <= '0;
            sumSet   <= '0;
            xSnap    <= '0;
            ySnap    <= '0;
            qSnap    <= '0;
            sumSnap  <= '0;
            clampQ   <= '0;
            issueCnt <= '0;
            drainCnt <= '0;
            busyQ    <= 1'b0;
            overrunQ <= 1'b0;
            toggleQ  <= 1'b0;
            validQ   <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                weightQ[i] <= '0;
                holdQ[i]   <= '0;
                magQ[i]    <= '0;
            end
        end else begin
            validQ <= 1'b0;

            // Setpoint writes land after any same-cycle snapshot reads the old value
            if (bus.xSetStrobe) xSet   <= $signed(bus.gpioData[SET_WIDTH-1:0]);
            if (bus.ySetStrobe) ySet   <= $signed(bus.gpioData[SET_WIDTH-1:0]);
            if (bus.qSetStrobe) qSet   <= $signed(bus.gpioData[SET_WIDTH-1:0]);
            if (bus.sSetStrobe) sumSet <= bus.gpioData[SUM_WIDTH-1:0];

            // A new overrun wins over a same-cycle clear
            overrunQ <= (bus.trigger && state != S_IDLE) ||
                        (overrunQ && !(bus.csrStrobe && bus.gpioData[DATA_WIDTH-1]));

            if (state == S_IDLE && bus.trigger) begin
                xSnap   <= xSet;
                ySnap   <= ySet;
                qSnap   <= qSet;
                sumSnap <= sumSet;
                busyQ   <= 1'b1;
            end

            if (state == S_WEIGHT) begin
                for (int i = 0; i < NUM_BUTTONS; i++) begin
                    weightQ[i] <= wRaw[i][WEIGHT_WIDTH-1] ? '0 : wRaw[i];
                    clampQ[i]  <= wRaw[i][WEIGHT_WIDTH-1];
                end
            end

            issueCnt <= (state == S_ISSUE) ? issueCnt + 2'd1 : 2'd0;
            drainCnt <= (state == S_DRAIN) ? drainCnt + CNT_WIDTH'(1) : '0;

            if (multValid) holdQ[multIdx] <= satMag;

            if (state == S_DONE) begin
                for (int i = 0; i < NUM_BUTTONS; i++) magQ[i] <= holdQ[i];
                toggleQ <= ~toggleQ;
                validQ  <= 1'b1;
                busyQ   <= 1'b0;
            end
        end
    end

    assign bus.csr       = {overrunQ, busyQ, clampQ, (DATA_WIDTH-6)'(0)};
    assign bus.mag0      = magQ[0];
    assign bus.mag1      = magQ[1];
    assign bus.mag2      = magQ[2];
    assign bus.mag3      = magQ[3];
    assign bus.magToggle = toggleQ;
    assign bus.magValid  = validQ;
endmodule

// File: tb/tb_button_magnitude_synth.sv
// Scoreboard bench for button_magnitude_synth: expected sets are queued at trigger time
// and compared when magValid pulses.
module tb_button_magnitude_synth;
    localparam int unsigned MAG_WIDTH    = 24;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned MULT_LATENCY = 3;
    localparam int unsigned LAT          = 6 + MULT_LATENCY;

    typedef struct packed {
        logic [3:0][23:0] mag;
        logic [3:0]       clamp;
        logic [63:0]      trigEdge;
    } expT;

    logic   clk = 1'b0;
    logic   resetN;
    longint cycle = 0;
    int     nCompared = 0;
    int     nMismatch = 0;
    int     validCount = 0;
    logic   expToggle = 1'b0;
    expT    sbQ [$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    bms_if #(.DATA_WIDTH(DATA_WIDTH), .MAG_WIDTH(MAG_WIDTH)) bus ();

    button_magnitude_synth #(
        .MAG_WIDTH    (MAG_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .MULT_LATENCY (MULT_LATENCY)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic expT mk(input int m0, input int m1, input int m2, input int m3,
                               input logic [3:0] cl);
        expT e;
        e.mag[0] = 24'(m0); e.mag[1] = 24'(m1); e.mag[2] = 24'(m2); e.mag[3] = 24'(m3);
        e.clamp = cl;
        e.trigEdge = '0;
        return e;
    endfunction

    // Reference: integer arithmetic on the sign table
    function automatic expT model(input int x, input int y, input int q, input int unsigned s);
        expT    e;
        longint w, p;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            w = 64'sd268435456;
            w += (i == 1 || i == 2) ? -longint'(x) : longint'(x);
            w += (i == 2 || i == 3) ? -longint'(y) : longint'(y);
            w += (i == 1 || i == 3) ? -longint'(q) : longint'(q);
            e.clamp[i] = (w < 0);
            if (w < 0) w = 0;
            p = (w * longint'(s)) >>> 30;
            if (p > 64'sd16777215) p = 64'sd16777215;
            e.mag[i] = 24'(p);
        end
        return e;
    endfunction

    // Output monitor / scoreboard pop
    always @(negedge clk) begin
        expT e;
        if (resetN === 1'b1 && bus.magValid === 1'b1) begin
            validCount++;
            if (sbQ.size() == 0) begin
                checkVal("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                expToggle = ~expToggle;
                checkVal("mag0", 64'(bus.mag0), 64'(e.mag[0]));
                checkVal("mag1", 64'(bus.mag1), 64'(e.mag[1]));
                checkVal("mag2", 64'(bus.mag2), 64'(e.mag[2]));
                checkVal("mag3", 64'(bus.mag3), 64'(e.mag[3]));
                checkVal("clampFlags", 64'(bus.csr[29:26]), 64'(e.clamp));
                checkVal("busy_cleared", 64'(bus.csr[30]), 64'd0);
                checkVal("toggle", 64'(bus.magToggle), 64'(expToggle));
                checkVal("latency", 64'(cycle) - e.trigEdge, 64'(LAT));
            end
        end
    end

    task automatic writeReg(input int sel, input logic [31:0] val);
        @(negedge clk);
        bus.gpioData = val;
        bus.xSetStrobe = (sel == 0);
        bus.ySetStrobe = (sel == 1);
        bus.qSetStrobe = (sel == 2);
        bus.sSetStrobe = (sel == 3);
        bus.csrStrobe  = (sel == 4);
        @(negedge clk);
        {bus.xSetStrobe, bus.ySetStrobe, bus.qSetStrobe, bus.sSetStrobe, bus.csrStrobe} = '0;
    endtask

    task automatic setAll(input int x, input int y, input int q, input int unsigned s);
        writeReg(0, 32'(x));
        writeReg(1, 32'(y));
        writeReg(2, 32'(q));
        writeReg(3, 32'(s));
    endtask

    task automatic fire(input expT e);
        @(negedge clk);
        bus.trigger = 1'b1;
        e.trigEdge = 64'(cycle + 1);
        sbQ.push_back(e);
        @(negedge clk);
        bus.trigger = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 60 && sbQ.size() != 0; i++) @(negedge clk);
        checkVal("timeout_pending", 64'(sbQ.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int   vc;
        int   rx, ry, rq;
        int unsigned rs;
        longint te;

        resetN = 1'b0;
        bus.gpioData = '0;
        {bus.xSetStrobe, bus.ySetStrobe, bus.qSetStrobe, bus.sSetStrobe, bus.csrStrobe} = '0;
        bus.trigger = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("rst_mag0", 64'(bus.mag0), 64'd0);
        checkVal("rst_mag3", 64'(bus.mag3), 64'd0);
        checkVal("rst_csr", 64'(bus.csr), 64'd0);
        checkVal("rst_toggle", 64'(bus.magToggle), 64'd0);
        checkVal("rst_valid", 64'(bus.magValid), 64'd0);
        resetN = 1'b1;
        @(negedge clk);

        // 1: centred
        setAll(0, 0, 0, 4000000);
        fire(mk(1000000, 1000000, 1000000, 1000000, 4'b0000));
        checkVal("busy_set", 64'(bus.csr[30]), 64'd1);
        waitDone();

        // 2: X=+0.5; outputs hold the previous set while busy
        setAll(32'h0800_0000, 0, 0, 4000000);
        fire(mk(1500000, 500000, 500000, 1500000, 4'b0000));
        repeat (3) @(negedge clk);
        checkVal("mag0_hold", 64'(bus.mag0), 64'd1000000);
        waitDone();

        // 3: X=Y=+1.0, w2 clamps
        setAll(32'h1000_0000, 32'h1000_0000, 0, 4000000);
        fire(mk(3000000, 1000000, 0, 1000000, 4'b0100));
        waitDone();

        // 4: X=Y=Q=+1.0, full-scale sum: w0=4 saturates, others exactly 0
        setAll(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h03FF_FFFF);
        fire(mk(24'hFFFFFF, 0, 0, 0, 4'b0000));
        waitDone();

        // 4b: Q=+1.5 clamps w1 and w3
        setAll(0, 0, 32'h1800_0000, 4000000);
        fire(mk(2500000, 0, 2500000, 0, 4'b1010));
        waitDone();

        // Random setpoints in [-1,+1] against the model
        for (int k = 0; k < 4; k++) begin
            rx = int'($urandom_range(32'h2000_0000)) - 32'sh1000_0000;
            ry = int'($urandom_range(32'h2000_0000)) - 32'sh1000_0000;
            rq = int'($urandom_range(32'h2000_0000)) - 32'sh1000_0000;
            rs = $urandom & 32'h03FF_FFFF;
            setAll(rx, ry, rq, rs);
            fire(model(rx, ry, rq, rs));
            waitDone();
        end

        // 5: trigger while busy is dropped and sets overrun
        setAll(0, 0, 0, 4000000);
        vc = validCount;
        fire(mk(1000000, 1000000, 1000000, 1000000, 4'b0000));
        @(negedge clk);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        waitDone();
        repeat (12) @(negedge clk);
        checkVal("one_valid", 64'(validCount - vc), 64'd1);
        checkVal("overrun_set", 64'(bus.csr[31]), 64'd1);
        writeReg(4, 32'h8000_0000);
        checkVal("overrun_clr", 64'(bus.csr[31]), 64'd0);

        // Clear and new overrun in the same cycle leave overrun set
        fire(mk(1000000, 1000000, 1000000, 1000000, 4'b0000));
        @(negedge clk);
        bus.trigger = 1'b1;
        bus.csrStrobe = 1'b1;
        bus.gpioData = 32'h8000_0000;
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.csrStrobe = 1'b0;
        checkVal("overrun_set_wins", 64'(bus.csr[31]), 64'd1);
        waitDone();
        writeReg(4, 32'h8000_0000);
        checkVal("overrun_clr2", 64'(bus.csr[31]), 64'd0);

        // Strobe and trigger together: snapshot uses the old X, next set the new one
        @(negedge clk);
        bus.gpioData = 32'h0800_0000;
        bus.xSetStrobe = 1'b1;
        bus.trigger = 1'b1;
        sbQ.push_back('{mag: mk(1000000, 1000000, 1000000, 1000000, 4'b0).mag,
                        clamp: 4'b0, trigEdge: 64'(cycle + 1)});
        @(negedge clk);
        bus.xSetStrobe = 1'b0;
        bus.trigger = 1'b0;
        waitDone();
        fire(mk(1500000, 500000, 500000, 1500000, 4'b0000));
        waitDone();

        // 6: reset during a set aborts it silently
        setAll(32'h0800_0000, 0, 0, 4000000);
        vc = validCount;
        fire(mk(1500000, 500000, 500000, 1500000, 4'b0000));
        te = cycle - 1;
        while (cycle < te + 4) @(negedge clk);
        resetN = 1'b0;
        sbQ.delete();
        expToggle = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("abort_mag0", 64'(bus.mag0), 64'd0);
        checkVal("abort_mag1", 64'(bus.mag1), 64'd0);
        checkVal("abort_toggle", 64'(bus.magToggle), 64'd0);
        checkVal("abort_csr", 64'(bus.csr), 64'd0);
        resetN = 1'b1;
        repeat (12) @(negedge clk);
        checkVal("abort_no_valid", 64'(validCount - vc), 64'd0);
        setAll(0, 32'h0800_0000, 0, 4000000);
        fire(mk(1500000, 1500000, 500000, 500000, 4'b0000));
        waitDone();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
